seven_seg_scanner: RTL

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_pkg.sv | 23 ++
 rtl/hex_to_seven_seg.sv | 14 +
 rtl/seven_seg_scanner.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared constants for the seven-segment scanner
package seven_seg_pkg;

   // Default number of multiplexed digits and the widest supported display
   localparam int DEFAULT_NUM_DIGITS = 4;
   localparam int MAX_NUM_DIGITS     = 8;

   // Scan state: values 0..MAX_NUM_DIGITS-1 are DIGIT_k, ST_BLANK is the post-reset dark state
   typedef logic [3:0] state_t;
   localparam state_t ST_BLANK = 4'd8;

   // Active-high segment patterns {g,f,e,d,c,b,a}, indexed by nibble value (entry 0 rightmost)
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // Encoding of DIGIT_k
   function automatic state_t digit_state(input int k);
      return state_t'(k);
   endfunction

endpackage

// File: rtl/hex_to_seven_seg.sv
// rtl/hex_to_seven_seg.sv - combinational nibble to active-high segment decode
module hex_to_seven_seg
   import seven_seg_pkg::*;
(
   input  logic [3:0] nibble_i,
   output logic [6:0] seg_o
);

   // Table lookup of the segment pattern for one hex digit
   always_comb begin
      seg_o = SEG_TABLE[nibble_i];
   end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed seven-segment scanner; SEVEN_SEG_BLANK_EN enables leading-zero blanking
module seven_seg_scanner
   import seven_seg_pkg::*;
#(
   parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
   parameter bit ACTIVE_LOW = 1'b1
)
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    scan_clock,
   input  logic                    enable,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic [NUM_DIGITS-1:0]   dp,
   output logic [NUM_DIGITS-1:0]   anode,
   output logic [6:0]              seg,
   output logic                    seg_dp
);

   localparam state_t LAST_DIGIT = digit_state(NUM_DIGITS - 1);

   // Pin levels meaning "inactive" after polarity is applied
   localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{ACTIVE_LOW}};
   localparam logic [6:0]            SEG_OFF   = {7{ACTIVE_LOW}};

   logic                    sync1_q, sync2_q, sync3_q;
   logic [1:0]              settle_q;
   logic                    armed_q;
   logic                    scan_edge;

   state_t                  state_q, state_d;
   logic [4*NUM_DIGITS-1:0] snap_value_q, snap_value_d;
   logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
   logic                    load_snap;

   logic [NUM_DIGITS-1:0]   blank_mask;
   logic [3:0]              nibble_d;
   logic [6:0]              seg_dec;
   logic                    dp_bit_d;
   logic                    lit_d;
   logic [NUM_DIGITS-1:0]   anode_hi_d;
   logic [6:0]              seg_hi_d;
   logic                    seg_dp_hi_d;

   logic [NUM_DIGITS-1:0]   anode_q;
   logic [6:0]              seg_q;
   logic                    seg_dp_q;

   // Two-flop synchronizer plus a history flop for rising-edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         sync3_q <= 1'b0;
      end else begin
         sync1_q <= scan_clock;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
      end
   end

   // Edge detection is armed only once the synchronized scan_clock has been seen low after
   // reset, so a level already high at release is not mistaken for a rising edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         settle_q <= 2'b00;
         armed_q  <= 1'b0;
      end else begin
         settle_q <= {settle_q[0], 1'b1};
         armed_q  <= armed_q | (settle_q[1] & ~sync2_q);
      end
   end

   assign scan_edge = armed_q & sync2_q & ~sync3_q;

   // State and frame-snapshot registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= ST_BLANK;
         snap_value_q <= '0;
         snap_dp_q    <= '0;
      end else begin
         state_q      <= state_d;
         snap_value_q <= snap_value_d;
         snap_dp_q    <= snap_dp_d;
      end
   end

   // Next state: advance one digit per scan edge, wrapping to DIGIT_0 and snapshotting on entry
   always_comb begin
      state_d      = state_q;
      load_snap    = 1'b0;
      if (scan_edge) begin
         if (state_q == ST_BLANK || state_q == LAST_DIGIT) begin
            state_d   = digit_state(0);
            load_snap = 1'b1;
         end else begin
            state_d   = state_q + 4'd1;
         end
      end
      snap_value_d = load_snap ? value : snap_value_q;
      snap_dp_d    = load_snap ? dp    : snap_dp_q;
   end

`ifdef SEVEN_SEG_BLANK_EN
   // A digit is dark when it and every more-significant nibble is zero, unless it is digit 0 or has its dp set
   always_comb begin
      blank_mask = '0;
      for (int k = 1; k < NUM_DIGITS; k++) begin
         blank_mask[k] = ~snap_dp_d[k] && ((snap_value_d >> (4 * k)) == '0);
      end
   end
`else
   // Every digit is displayed, leading zeros included
   always_comb begin
      blank_mask = '0;
   end
`endif

   // Output decode from the next state so pins change on the same edge the state does
   always_comb begin
      nibble_d   = 4'h0;
      dp_bit_d   = 1'b0;
      lit_d      = 1'b0;
      anode_hi_d = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (state_d == digit_state(k)) begin
            nibble_d      = snap_value_d[4*k +: 4];
            dp_bit_d      = snap_dp_d[k];
            lit_d         = enable & ~blank_mask[k];
            anode_hi_d[k] = enable & ~blank_mask[k];
         end
      end
   end

   hex_to_seven_seg u_decode (
      .nibble_i (nibble_d),
      .seg_o    (seg_dec)
   );

   // Gate the decoded segments and decimal point with the lit condition
   always_comb begin
      seg_hi_d    = lit_d ? seg_dec : 7'h00;
      seg_dp_hi_d = lit_d & dp_bit_d;
   end

   // Pin registers hold pin-level values; polarity is applied after the active-high logic
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         anode_q  <= ANODE_OFF;
         seg_q    <= SEG_OFF;
         seg_dp_q <= ACTIVE_LOW;
      end else begin
         anode_q  <= anode_hi_d ^ ANODE_OFF;
         seg_q    <= seg_hi_d ^ SEG_OFF;
         seg_dp_q <= seg_dp_hi_d ^ ACTIVE_LOW;
      end
   end

   assign anode  = anode_q;
   assign seg    = seg_q;
   assign seg_dp = seg_dp_q;

endmodule
